// File: rtl/xgmii_link_fault_32.sv
// Link fault sequencer for the 32-bit XGMII RX path: detects local/remote fault
// ordered sets, runs the fault state machine and gates the stream to idles while faulted.
module xgmii_link_fault_32 #(
  parameter int unsigned COL_CNT_MAX = 128,
  parameter int unsigned SEQ_THRESH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_xgmii_rxd,
  input  logic [3:0]  s_xgmii_rxc,
  output logic [31:0] m_xgmii_rxd,
  output logic [3:0]  m_xgmii_rxc,
  output logic        local_fault,
  output logic        remote_fault,
  output logic        tx_send_rf,
  output logic        tx_send_idle,
  output logic        fault_change
);

  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 4;
  localparam int unsigned COLW = 8;
  localparam int unsigned SEQW = 3;

  localparam logic [DW-1:0] IDLE_D  = 32'h07070707;
  localparam logic [CW-1:0] IDLE_C  = 4'hF;
  localparam logic [DW-1:0] ABORT_D = 32'h070707FE;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_last_remote;
  logic [SEQW-1:0] r_seq_cnt;
  logic [COLW-1:0] r_col_cnt;
  logic            r_local_fault;
  logic            r_remote_fault;
  logic            r_fault_change;
  logic            r_in_frame;
  logic            r_gate_d;
  logic [DW-1:0]   r_rxd;
  logic [CW-1:0]   r_rxc;

  logic w_is_seq;
  logic w_seq_remote;
  logic w_same_type;
  logic w_start;
  logic w_term;
  logic w_gate;
  logic w_col_done;
  logic w_seq_done;

  assign w_is_seq = (s_xgmii_rxc == 4'b0001) && (s_xgmii_rxd[7:0] == 8'h9C) &&
                    (s_xgmii_rxd[23:8] == 16'h0000) &&
                    ((s_xgmii_rxd[31:24] == 8'h01) || (s_xgmii_rxd[31:24] == 8'h02));
  assign w_seq_remote = (s_xgmii_rxd[31:24] == 8'h02);
  assign w_same_type  = (w_seq_remote == r_last_remote);
  assign w_start      = s_xgmii_rxc[0] && (s_xgmii_rxd[7:0] == 8'hFB);
  assign w_gate       = r_local_fault | r_remote_fault;
  assign w_col_done   = ((r_col_cnt + COLW'(1)) == COLW'(COL_CNT_MAX));
  assign w_seq_done   = ((r_seq_cnt + SEQW'(1)) == SEQW'(SEQ_THRESH));

  // Terminate may sit in any lane
  always_comb begin
    w_term = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (s_xgmii_rxc[i] && (s_xgmii_rxd[8*i +: 8] == 8'hFD)) w_term = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_INIT;
      r_last_remote  <= 1'b0;
      r_seq_cnt      <= '0;
      r_col_cnt      <= '0;
      r_local_fault  <= 1'b0;
      r_remote_fault <= 1'b0;
      r_fault_change <= 1'b0;
      r_in_frame     <= 1'b0;
      r_gate_d       <= 1'b0;
      r_rxd          <= IDLE_D;
      r_rxc          <= IDLE_C;
    end else begin
      r_fault_change <= 1'b0;
      r_gate_d       <= w_gate;

      // Terminate wins over a start in the same word
      if (w_term) begin
        r_in_frame <= 1'b0;
      end else if (w_start) begin
        r_in_frame <= 1'b1;
      end

      // Abort an open frame with an error code the first time the gate closes
      if (!w_gate) begin
        r_rxd <= s_xgmii_rxd;
        r_rxc <= s_xgmii_rxc;
      end else if (!r_gate_d && r_in_frame) begin
        r_rxd <= ABORT_D;
        r_rxc <= IDLE_C;
      end else begin
        r_rxd <= IDLE_D;
        r_rxc <= IDLE_C;
      end

      case (r_state)
        ST_INIT: begin
          if (w_is_seq) begin
            r_state       <= ST_COUNT;
            r_last_remote <= w_seq_remote;
            r_seq_cnt     <= SEQW'(1);
            r_col_cnt     <= '0;
          end
        end
        ST_COUNT: begin
          if (w_is_seq && w_same_type) begin
            if (w_seq_done) begin
              r_state        <= ST_FAULT;
              r_seq_cnt      <= SEQW'(SEQ_THRESH);
              r_col_cnt      <= '0;
              r_local_fault  <= ~r_last_remote;
              r_remote_fault <= r_last_remote;
              r_fault_change <= (r_local_fault == r_last_remote) ||
                                (r_remote_fault != r_last_remote);
            end else begin
              r_seq_cnt <= r_seq_cnt + SEQW'(1);
            end
          end else if (w_is_seq) begin
            r_last_remote <= w_seq_remote;
            r_seq_cnt     <= SEQW'(1);
            r_col_cnt     <= '0;
          end else begin
            r_col_cnt <= r_col_cnt + COLW'(1);
            if (w_col_done) begin
              r_state        <= ST_INIT;
              r_local_fault  <= 1'b0;
              r_remote_fault <= 1'b0;
              r_fault_change <= w_gate;
            end
          end
        end
        ST_FAULT: begin
          if (w_is_seq && w_same_type) begin
            r_col_cnt <= '0;
          end else if (w_is_seq) begin
            // Held faults stay asserted until the new type is declared or times out
            r_state       <= ST_COUNT;
            r_last_remote <= w_seq_remote;
            r_seq_cnt     <= SEQW'(1);
            r_col_cnt     <= '0;
          end else begin
            r_col_cnt <= r_col_cnt + COLW'(1);
            if (w_col_done) begin
              r_state        <= ST_INIT;
              r_local_fault  <= 1'b0;
              r_remote_fault <= 1'b0;
              r_fault_change <= w_gate;
            end
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign m_xgmii_rxd  = r_rxd;
  assign m_xgmii_rxc  = r_rxc;
  assign local_fault  = r_local_fault;
  assign remote_fault = r_remote_fault;
  assign tx_send_rf   = r_local_fault;
  assign tx_send_idle = r_remote_fault;
  assign fault_change = r_fault_change;

endmodule

// File: tb/tb_xgmii_link_fault_32.sv
// Scoreboard bench for xgmii_link_fault_32: directed test-plan scenarios followed by
// randomized bursts, all checked against a behavioural model of the fault rules.
module tb_xgmii_link_fault_32;

  localparam int COL_MAX = 128;
  localparam int THRESH  = 4;

  logic        clk;
  logic        rst;
  logic [31:0] s_xgmii_rxd;
  logic [3:0]  s_xgmii_rxc;
  logic [31:0] m_xgmii_rxd;
  logic [3:0]  m_xgmii_rxc;
  logic        local_fault;
  logic        remote_fault;
  logic        tx_send_rf;
  logic        tx_send_idle;
  logic        fault_change;

  xgmii_link_fault_32 #(.COL_CNT_MAX(COL_MAX), .SEQ_THRESH(THRESH)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_xgmii_rxd  (s_xgmii_rxd),
    .s_xgmii_rxc  (s_xgmii_rxc),
    .m_xgmii_rxd  (m_xgmii_rxd),
    .m_xgmii_rxc  (m_xgmii_rxc),
    .local_fault  (local_fault),
    .remote_fault (remote_fault),
    .tx_send_rf   (tx_send_rf),
    .tx_send_idle (tx_send_idle),
    .fault_change (fault_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  c;
    logic        lf;
    logic        rf;
    logic        srf;
    logic        sidle;
    logic        chg;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_no   = 0;

  // Model: mode 0 = waiting, 1 = counting, 2 = declared; fault holds 0/1(local)/2(remote)
  int mode, last_type, nseq, ncol, fault, prev_fault;
  bit in_frame;

  task automatic model_step(input logic [31:0] d, input logic [3:0] c, input logic r);
    obs_t e;
    int   typ;
    bit   term;
    if (r) begin
      mode = 0; last_type = 0; nseq = 0; ncol = 0; fault = 0; prev_fault = 0;
      in_frame = 1'b0;
      e = '{d: 32'h07070707, c: 4'hF, lf: 1'b0, rf: 1'b0, srf: 1'b0, sidle: 1'b0, chg: 1'b0};
    end else begin
      typ = 0;
      if (c == 4'b0001 && d[7:0] == 8'h9C && d[23:8] == 16'h0 &&
          (d[31:24] == 8'h01 || d[31:24] == 8'h02)) typ = int'(d[31:24]);
      // Output word uses the fault state as it stood when this word arrived
      if (fault == 0) begin
        e.d = d; e.c = c;
      end else if (prev_fault == 0 && in_frame) begin
        e.d = 32'h070707FE; e.c = 4'hF;
      end else begin
        e.d = 32'h07070707; e.c = 4'hF;
      end
      prev_fault = fault;
      term = 1'b0;
      for (int i = 0; i < 4; i++) if (c[i] && d[8*i +: 8] == 8'hFD) term = 1'b1;
      if (term) in_frame = 1'b0;
      else if (c[0] && d[7:0] == 8'hFB) in_frame = 1'b1;
      if (typ != 0) begin
        if (mode == 0 || typ != last_type) begin
          mode = 1; last_type = typ; nseq = 1; ncol = 0;
        end else if (mode == 1) begin
          nseq++;
          if (nseq == THRESH) begin mode = 2; fault = typ; ncol = 0; end
        end else begin
          ncol = 0;
        end
      end else if (mode != 0) begin
        ncol++;
        if (ncol == COL_MAX) begin mode = 0; fault = 0; end
      end
      e.lf = (fault == 1); e.rf = (fault == 2);
      e.srf = e.lf; e.sidle = e.rf;
      e.chg = (fault != prev_fault);
    end
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [31:0] d, input logic [3:0] c, input logic r);
    @(negedge clk);
    s_xgmii_rxd = d;
    s_xgmii_rxc = c;
    rst         = r;
    model_step(d, c, r);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) cyc(32'h07070707, 4'hF, 1'b0);
  endtask

  task automatic seqs(input int typ, input int n);
    logic [31:0] w;
    w = {8'(typ), 24'h00009C};
    for (int i = 0; i < n; i++) cyc(w, 4'h1, 1'b0);
  endtask

  task automatic payload(input int n);
    for (int i = 0; i < n; i++) cyc($urandom, 4'h0, 1'b0);
  endtask

  task automatic frame_start();
    cyc(32'h555555FB, 4'h1, 1'b0);
  endtask

  task automatic frame_end();
    cyc(32'h070707FD, 4'hF, 1'b0);
  endtask

  // Monitor: one output word per clock, compared against the head of the queue
  always @(posedge clk) begin
    obs_t a, e;
    #1;
    cyc_no++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{d: m_xgmii_rxd, c: m_xgmii_rxc, lf: local_fault, rf: remote_fault,
            srf: tx_send_rf, sidle: tx_send_idle, chg: fault_change};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        if (n_errors <= 25)
          $display("FAIL out cycle %0d: got d=%h c=%h lf=%b rf=%b srf=%b sidle=%b chg=%b, expected d=%h c=%h lf=%b rf=%b srf=%b sidle=%b chg=%b",
                   cyc_no, a.d, a.c, a.lf, a.rf, a.srf, a.sidle, a.chg,
                   e.d, e.c, e.lf, e.rf, e.srf, e.sidle, e.chg);
      end
    end
  end

  initial begin
    rst = 1'b1;
    s_xgmii_rxd = 32'h07070707;
    s_xgmii_rxc = 4'hF;
    cyc(32'h07070707, 4'hF, 1'b1);
    cyc(32'h0100009C, 4'h1, 1'b1);
    idles(3);

    // Local declare, then type switch to remote
    seqs(1, 4);
    idles(5);
    seqs(2, 4);
    idles(3);

    // Clear: 127 idles, refresh, then the full timeout
    cyc(32'h07070707, 4'hF, 1'b1);
    seqs(1, 4);
    idles(127);
    seqs(1, 1);
    idles(130);

    // Partial count abandoned, then a restarted count with gaps
    seqs(1, 3);
    idles(128);
    seqs(1, 1);
    idles(3);
    seqs(1, 3);
    idles(130);

    // 9C with a foreign type code or stray bytes is not a sequence
    for (int i = 0; i < 4; i++) cyc(32'h0300009C, 4'h1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(32'h0101009C, 4'h1, 1'b0);
    idles(130);

    // Fault declared mid-frame
    frame_start();
    payload(2);
    seqs(1, 4);
    payload(3);
    frame_end();
    idles(4);

    // Reset while faulted
    cyc(32'h07070707, 4'hF, 1'b1);
    frame_start();
    payload(2);
    frame_end();
    idles(2);

    // Randomized bursts
    for (int p = 0; p < 260; p++) begin
      case ($urandom_range(0, 8))
        0, 1: seqs(1, $urandom_range(1, 5));
        2, 3: seqs(2, $urandom_range(1, 5));
        4:    idles($urandom_range(1, 140));
        5: begin
          frame_start();
          payload($urandom_range(0, 6));
          if ($urandom_range(0, 1) == 1) seqs($urandom_range(1, 2), $urandom_range(1, 4));
          payload($urandom_range(0, 3));
          frame_end();
        end
        6:    for (int i = 0; i < 3; i++) cyc($urandom, 4'($urandom_range(0, 15)), 1'b0);
        7: begin
          if ($urandom_range(0, 1) == 1) cyc(32'h0300009C, 4'h1, 1'b0);
          else cyc(32'h0200009C, 4'h3, 1'b0);
        end
        default: begin
          if ($urandom_range(0, 4) == 0) cyc(32'h07070707, 4'hF, 1'b1);
          else idles($urandom_range(100, 135));
        end
      endcase
    end
    idles(3);

    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
